// File: rtl/mem_rmw_unit_pkg.sv
// mem_rmw_unit_pkg: function codes, FSM states and access-classification helpers
// for the data-side memory read-modify-write unit.
package mem_rmw_unit_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_fn_e;

    typedef enum logic {S_IDLE, S_RD} state_e;

    function automatic logic is_load(mem_fn_e fn);
        return fn inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_fn_e fn);
        return fn inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_misaligned(mem_fn_e fn, logic [1:0] lane);
        return (fn inside {MEM_LH, MEM_LHU, MEM_SH} && lane[0]) ||
               (fn inside {MEM_LW, MEM_SW} && lane != 2'd0);
    endfunction

endpackage

// File: rtl/mem_rmw_unit_lane_align.sv
// mem_lane_align: combinational lane handling for one RAM word.
//   fn         in  access function code
//   lane       in  byte offset within the word
//   word       in  word read from RAM
//   wdata      in  right-aligned store data (byte or half)
//   load_data  out lane-selected, sign/zero-extended load result
//   store_word out word with the addressed byte/half replaced by wdata
module mem_lane_align
    import mem_rmw_unit_pkg::*;
(
    input  mem_fn_e     fn,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    logic [31:0] rep;

    always_comb begin
        b          = word[{lane, 3'b000} +: 8];
        h          = lane[1] ? word[31:16] : word[15:0];
        load_data  = fn == MEM_LB  ? {{24{b[7]}}, b} :
                     fn == MEM_LBU ? {24'd0, b} :
                     fn == MEM_LH  ? {{16{h[15]}}, h} :
                     fn == MEM_LHU ? {16'd0, h} : word;
        mask       = fn == MEM_SB ? 32'hFF << {lane, 3'b000} :
                     fn == MEM_SH ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'h0;
        // Replicating the store data lets one mask pick whichever lane is addressed.
        rep        = fn == MEM_SB ? {4{wdata[7:0]}} : {2{wdata}};
        store_word = (word & ~mask) | (rep & mask);
    end
endmodule

// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: CPU load/store front end for a word-wide 1-cycle-latency RAM;
// sub-word stores by read-modify-write, extended loads, misalignment rejection.
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_fn/req_addr/req_wdata   function code, byte address, right-aligned store data
//   rsp_valid/rsp_rdata         one-cycle load result
//   misalign                    one-cycle pulse for a rejected misaligned access
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  word RAM port
module mem_rmw_unit
    import mem_rmw_unit_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fn,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    state_e            state, state_nx;
    mem_fn_e           fn_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] word_q;
    logic [15:0]       wdata_q;
    logic [31:0]       load_data, store_word;
    mem_fn_e           fn_in;
    logic              accept, bad, go;
    logic              unused_addr;

    assign fn_in       = mem_fn_e'(req_fn);
    assign req_ready   = (state == S_IDLE) & rst_n;
    assign accept      = req_valid & req_ready;
    assign bad         = is_misaligned(fn_in, req_addr[1:0]);
    assign go          = accept & ~bad & (is_load(fn_in) | is_store(fn_in));
    // Address bits above the RAM word range alias by design.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    mem_lane_align u_align (
        .fn        (fn_q),
        .lane      (lane_q),
        .word      (ram_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fn_q      <= MEM_LB;
            lane_q    <= 2'd0;
            word_q    <= '0;
            wdata_q   <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= (state == S_RD) & is_load(fn_q);
            misalign  <= accept & bad;
            if (state == S_RD && is_load(fn_q))
                rsp_rdata <= load_data;
            if (accept) begin
                fn_q    <= fn_in;
                lane_q  <= req_addr[1:0];
                word_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr[ADDR_W+1:2];
        ram_wdata = req_wdata;
        if (state == S_RD) begin
            state_nx = S_IDLE;
            // Write-back half of a sub-word store; suppressed while reset is asserted.
            if (rst_n && is_store(fn_q)) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = word_q;
                ram_wdata = store_word;
            end
        end else if (go) begin
            ram_en   = 1'b1;
            ram_we   = fn_in == MEM_SW;
            state_nx = fn_in == MEM_SW ? S_IDLE : S_RD;
        end
    end
endmodule

// File: tb/tb_mem_rmw_unit.sv
// tb_mem_rmw_unit: directed stimulus with scoreboard queues for load responses and RAM writes.
module tb_mem_rmw_unit;
    import mem_rmw_unit_pkg::*;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_fn;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          misalign;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   exp_rsp[$];
    logic [AW-1:0] exp_waddr[$];
    logic [31:0]   exp_wdata[$];
    logic          no_ram = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    mem_rmw_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_fn(req_fn), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign(misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: pops expected load results and RAM writes as the DUT presents them.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_rdata, 32'hDEAD_DEAD);
            else chk("rsp_rdata", rsp_rdata, exp_rsp.pop_front());
        end
        if (rst_n && ram_en && ram_we) begin
            if (exp_waddr.size() == 0) chk("unexpected_write", ram_wdata, 32'hDEAD_DEAD);
            else begin
                chk("write_addr", 32'(ram_addr), 32'(exp_waddr.pop_front()));
                chk("write_data", ram_wdata, exp_wdata.pop_front());
            end
        end
        if (no_ram) chk("no_ram_en", 32'(ram_en), 32'd0);
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        exp_waddr.push_back(a);
        exp_wdata.push_back(d);
    endtask

    // Presents a request for one cycle starting just after a rising edge; returns mid-cycle.
    task automatic req(input mem_fn_e fn, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_fn    = fn;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic load(input mem_fn_e fn, input logic [31:0] a, input logic [31:0] exp);
        exp_rsp.push_back(exp);
        req(fn, a, 32'h0);
        chk("ld_read_en", 32'({ram_en, ram_we}), 32'b10);
        idle();
        @(negedge clk);
        chk("ld_rd_ready", 32'(req_ready), 32'd0);
        chk("ld_rd_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic rmw(input mem_fn_e fn, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_word);
        push_wr(a[AW+1:2], exp_word);
        req(fn, a, d);
        chk("rmw_read", 32'({ram_en, ram_we}), 32'b10);
        idle();
        @(negedge clk);
        chk("rmw_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rmw_ready", 32'(req_ready), 32'd1);
        chk("rmw_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    task automatic bad(input mem_fn_e fn, input logic [31:0] a);
        no_ram = 1'b1;
        req(fn, a, 32'h1111_1111);
        idle();
        @(negedge clk);
        chk("misalign_pulse", 32'(misalign), 32'd1);
        chk("misalign_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("misalign_clear", 32'(misalign), 32'd0);
        chk("misalign_no_rsp", 32'(rsp_valid), 32'd0);
        no_ram = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_fn = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        push_wr(14'h10, 32'h1122_3344);
        req(MEM_SW, 32'h40, 32'h1122_3344);
        chk("sw_ready", 32'(req_ready), 32'd1);
        load(MEM_LW, 32'h40, 32'h1122_3344);

        rmw(MEM_SB, 32'h42, 32'h0000_00AB, 32'h11AB_3344);
        load(MEM_LW, 32'h40, 32'h11AB_3344);

        push_wr(14'h20, 32'h8001_7F80);
        req(MEM_SW, 32'h80, 32'h8001_7F80);
        load(MEM_LH,  32'h82, 32'hFFFF_8001);
        load(MEM_LHU, 32'h82, 32'h0000_8001);
        load(MEM_LB,  32'h80, 32'hFFFF_FF80);
        load(MEM_LBU, 32'h81, 32'h0000_007F);
        rmw(MEM_SH, 32'h82, 32'h0000_BEEF, 32'hBEEF_7F80);
        rmw(MEM_SH, 32'h80, 32'h0000_1234, 32'hBEEF_1234);
        rmw(MEM_SB, 32'h83, 32'h0000_005A, 32'h5AEF_1234);
        load(MEM_LB, 32'h83, 32'h0000_005A);
        load(MEM_LH, 32'h80, 32'h0000_1234);

        push_wr(14'h11, 32'hCAFE_F00D);
        req(MEM_SW, 32'h44, 32'hCAFE_F00D);
        idle();
        bad(MEM_SH, 32'h45);
        bad(MEM_LW, 32'h46);
        bad(MEM_LHU, 32'h43);
        load(MEM_LW, 32'h44, 32'hCAFE_F00D);

        req(MEM_SB, 32'h40, 32'h0000_0077);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_rd_we", 32'({ram_en, ram_we}), 32'b00);
        chk("rst_rd_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_idle", 32'(req_ready), 32'd1);
        load(MEM_LW, 32'h40, 32'h11AB_3344);

        for (int i = 0; i < 4; i++) push_wr(AW'(14'h40 + i), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            req(MEM_SW, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            chk("burst_ready", 32'(req_ready), 32'd1);
        end
        idle();
        load(MEM_LW, 32'h10C, 32'hA000_0003);
        load(MEM_LW, 32'h100, 32'hA000_0000);

        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        chk("write_queue_empty", 32'(exp_waddr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
